// File: rtl/infrarojo_emisor.sv
// IR emitter strobe and receiver sampler for the 5-channel line sensor.
// Each frame samples ambient (emitter off) then reflection (emitter on), and debounces on & ~ambient.
module infrarojo_emisor #(
  parameter int SETTLE_CYC = 500,
  parameter int PERIOD_CYC = 100000,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [4:0] i_sens,
  output logic       o_emit,
  output logic [4:0] o_line,
  output logic       o_valid,
  output logic       o_amb_err
);

  localparam int CW = $clog2(PERIOD_CYC);
  localparam int DW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] CNT_AMB_END = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ON_END  = CW'(2 * SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD_CYC - 1);
  localparam logic [DW-1:0] DEB_MAX     = DW'(DEB_FRAMES);

  typedef enum logic [2:0] {IDLE, AMB, ON, EVAL, HOLD} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [4:0]    sensMeta, sSens;
  logic [4:0]    ambSample, onSample;
  logic [4:0]    prevRaw;
  logic [DW-1:0] dcnt;
  logic          ambCapture, onCapture, evalFire;

  logic [4:0]    raw;
  logic          rawMatch;
  logic [DW-1:0] dcntInc, dcntPost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    ambCapture = 1'b0;
    onCapture  = 1'b0;
    evalFire   = 1'b0;
    if (!i_en) begin
      // Disabling abandons the frame wherever it is.
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      if (state == IDLE || cnt == CNT_LAST) begin
        cntNext = '0;
      end else begin
        cntNext = cnt + CW'(1);
      end
      case (state)
        IDLE: stateNext = AMB;
        AMB: begin
          if (cnt == CNT_AMB_END) begin
            stateNext  = ON;
            ambCapture = 1'b1;
          end
        end
        ON: begin
          if (cnt == CNT_ON_END) begin
            stateNext = EVAL;
            onCapture = 1'b1;
          end
        end
        EVAL: begin
          stateNext = HOLD;
          evalFire  = 1'b1;
        end
        HOLD: begin
          if (cnt == CNT_LAST) begin
            stateNext = AMB;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign raw      = onSample & ~ambSample;
  assign rawMatch = (raw == prevRaw);
  assign dcntInc  = (dcnt == DEB_MAX) ? dcnt : dcnt + DW'(1);
  assign dcntPost = rawMatch ? dcntInc : DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensMeta  <= '0;
      sSens     <= '0;
      ambSample <= '0;
      onSample  <= '0;
      prevRaw   <= '0;
      dcnt      <= '0;
      o_emit    <= 1'b0;
      o_line    <= '0;
      o_valid   <= 1'b0;
      o_amb_err <= 1'b0;
    end else begin
      sensMeta <= i_sens;
      sSens    <= sensMeta;
      if (ambCapture) begin
        ambSample <= sSens;
      end
      if (onCapture) begin
        onSample <= sSens;
      end
      // Emitter follows the next state so it is a clean register output.
      o_emit  <= (stateNext == ON);
      o_valid <= evalFire;
      if (!i_en) begin
        prevRaw <= '0;
        dcnt    <= '0;
      end else if (evalFire) begin
        prevRaw   <= raw;
        dcnt      <= dcntPost;
        o_amb_err <= |ambSample;
        if (dcntPost == DEB_MAX) begin
          o_line <= raw;
        end
      end
    end
  end

endmodule

// File: tb/tb_infrarojo_emisor.sv
// Scoreboard bench for infrarojo_emisor with SETTLE=4, PERIOD=16, DEB=2.
// Stimulus queues expected per-frame results; a monitor checks them on every o_valid.
module tb_infrarojo_emisor;

  logic       clk;
  logic       rst_n;
  logic       i_en;
  logic [4:0] i_sens;
  logic       o_emit;
  logic [4:0] o_line;
  logic       o_valid;
  logic       o_amb_err;

  logic       sensMode;
  logic [4:0] sensPat;

  typedef struct packed {
    logic [4:0] line;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   nVec  = 0;
  int   nMiss = 0;
  int   nFrame = 0;

  infrarojo_emisor #(
    .SETTLE_CYC(4),
    .PERIOD_CYC(16),
    .DEB_FRAMES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (i_en),
    .i_sens   (i_sens),
    .o_emit   (o_emit),
    .o_line   (o_line),
    .o_valid  (o_valid),
    .o_amb_err(o_amb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode 1: receivers see the pattern only while the emitter is on (pure reflection).
  assign i_sens = sensMode ? (o_emit ? sensPat : 5'b00000) : sensPat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      exp_t e;
      nFrame++;
      if (expQ.size() == 0) begin
        nVec++;
        nMiss++;
        $display("FAIL unexpected_valid: got line=%b amb_err=%b expected no frame", o_line, o_amb_err);
      end else begin
        e = expQ.pop_front();
        $display("frame %0d: line=%b amb_err=%b (exp %b/%b)", nFrame, o_line, o_amb_err, e.line, e.err);
        chk("frame_line", 32'(o_line), 32'(e.line));
        chk("frame_amb_err", 32'(o_amb_err), 32'(e.err));
      end
    end
  end

  task automatic push(input logic [4:0] line, input logic err);
    exp_t e;
    e.line = line;
    e.err  = err;
    expQ.push_back(e);
  endtask

  // Runs nCyc cycles of a frame starting at cnt 0, checking emitter window and valid timing.
  task automatic runFrame(input logic mode, input logic [4:0] pat, input int nCyc);
    sensMode = mode;
    sensPat  = pat;
    for (int k = 0; k < nCyc; k++) begin
      @(posedge clk);
      #1;
      chk("emit_window", 32'(o_emit), 32'(k >= 4 && k <= 7));
      chk("valid_timing", 32'(o_valid), 32'(k == 9));
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    i_en     = 1'b0;
    sensMode = 1'b1;
    sensPat  = 5'b00000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_emit", 32'(o_emit), 32'h0);
    chk("reset_line", 32'(o_line), 32'h0);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_amb_err", 32'(o_amb_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_en = 1'b1;

    // Centre channel reflects only: debounced after the second frame.
    push(5'b00000, 1'b0);
    push(5'b00100, 1'b0);
    runFrame(1'b1, 5'b00100, 16);
    runFrame(1'b1, 5'b00100, 16);

    // Constant IR on all channels: raw 0, ambient error each frame.
    push(5'b00100, 1'b1);
    push(5'b00000, 1'b1);
    runFrame(1'b0, 5'b11111, 16);
    runFrame(1'b0, 5'b11111, 16);

    // Alternating raw never settles.
    push(5'b00000, 1'b0);
    push(5'b00000, 1'b0);
    push(5'b00000, 1'b0);
    push(5'b00000, 1'b0);
    runFrame(1'b1, 5'b00001, 16);
    runFrame(1'b1, 5'b00010, 16);
    runFrame(1'b1, 5'b00001, 16);
    runFrame(1'b1, 5'b00010, 16);

    // Settle on 00100, then one frame of 00001 leaves prev_raw=00001 with dcnt=1.
    push(5'b00000, 1'b0);
    push(5'b00100, 1'b0);
    push(5'b00100, 1'b0);
    runFrame(1'b1, 5'b00100, 16);
    runFrame(1'b1, 5'b00100, 16);
    runFrame(1'b1, 5'b00001, 16);

    // Drop enable at cnt 6.
    runFrame(1'b1, 5'b00001, 7);
    i_en = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_emit_off", 32'(o_emit), 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("idle_no_valid", 32'(o_valid), 32'h0);
      chk("idle_emit_off", 32'(o_emit), 32'h0);
    end
    chk("drop_line_kept", 32'(o_line), 32'h04);
    chk("drop_amb_err_kept", 32'(o_amb_err), 32'h0);

    // Re-enable: debounce history was cleared, so 00001 needs two fresh frames.
    @(negedge clk);
    i_en = 1'b1;
    push(5'b00100, 1'b0);
    push(5'b00001, 1'b0);
    runFrame(1'b1, 5'b00001, 16);
    runFrame(1'b1, 5'b00001, 16);

    // Asynchronous reset while the emitter is on.
    runFrame(1'b1, 5'b00001, 6);
    rst_n = 1'b0;
    #1;
    chk("async_rst_emit", 32'(o_emit), 32'h0);
    chk("async_rst_line", 32'(o_line), 32'h0);
    chk("async_rst_valid", 32'(o_valid), 32'h0);
    chk("async_rst_amb_err", 32'(o_amb_err), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_emit", 32'(o_emit), 32'h0);
    chk("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
